mhd_stream_accumulator: RTL and testbench
=========================================

MHD_STREAM_ACCUMULATOR -- requirements
Module: mhd_stream_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 64, giving the operand width in bits.
REQ-002 SHALL have parameter CNT_W, default 32, giving the sample-counter width in bits.
REQ-003 SHALL define HD_W = clog2(WIDTH+1), which is 7 for WIDTH=64.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  begin a measurement run; sampled only in IDLE or DONE.
REQ-007 num_samples  input  CNT_W  number of samples in the run; captured when start is accepted.
REQ-008 in_valid  input  1  a/b pair present.
REQ-009 in_ready  output  1  block accepts the a/b pair.
REQ-010 a  input  WIDTH  exact-circuit output word.
REQ-011 b  input  WIDTH  approximate-circuit output word.
REQ-012 busy  output  1  high in RUN and DRAIN.
REQ-013 done  output  1  high in DONE; results are valid.
REQ-014 sum_hd  output  CNT_W+HD_W  sum of Hamming distances over the run.
REQ-015 max_hd  output  HD_W  largest single-sample Hamming distance in the run.
REQ-016 err_cnt  output  CNT_W  count of samples with Hamming distance != 0.

Function
REQ-017 SHALL compute the per-sample Hamming distance as popcount(a XOR b), with range 0..WIDTH.
REQ-018 SHALL implement the FSM states IDLE, RUN, DRAIN and DONE.
REQ-019 IDLE or DONE, start=1, num_samples>0: clear sum_hd, max_hd and err_cnt; load remaining=num_samples; go to RUN.
REQ-020 IDLE or DONE, start=1, num_samples=0: clear sum_hd, max_hd and err_cnt; go to DONE in the next cycle.
REQ-021 in_ready = (state==RUN) AND (remaining!=0), with no combinational path from in_valid.
REQ-022 A handshake occurs on a cycle with in_valid AND in_ready; on that edge, remaining decrements and the distance is registered in stage 1 (hd_q, hd_v).
REQ-023 Stage 2, on the edge after stage 1: sum_hd += hd_q; max_hd = max(max_hd, hd_q); err_cnt += (hd_q!=0).
REQ-024 RUN -> DRAIN on the edge where the final handshake is taken.
REQ-025 DRAIN -> DONE after stage 1 has retired into the accumulators.
REQ-026 done SHALL rise exactly 2 cycles after the final handshake cycle.
REQ-027 Accumulators SHALL hold their values in DONE until the next accepted start or rst.
REQ-028 start SHALL be ignored in RUN and DRAIN.
REQ-029 in_valid outside RUN SHALL be ignored, with no state change.
REQ-030 Stalls: in_valid low in RUN SHALL leave remaining and the accumulators unchanged; stage 1 inserts a bubble (hd_v=0).
REQ-031 sum_hd SHALL never overflow (maximum (2^CNT_W - 1)*WIDTH); no saturation logic.
REQ-032 max_hd SHALL report the value WIDTH when a = ~b.
REQ-033 start in DONE on the same cycle as any other input SHALL take effect as in REQ-019 and REQ-020.

Reset
REQ-034 rst SHALL force state=IDLE, remaining=0, hd_v=0 and all outputs to 0 (in_ready, busy, done, sum_hd, max_hd, err_cnt).
REQ-035 rst SHALL take priority over start and over any handshake in the same cycle.
REQ-036 rst mid-run SHALL abort the run, discard partial results, and deassert in_ready on the next cycle.

Structure
REQ-037 Shared package mhd_pkg SHALL hold the WIDTH/CNT_W defaults, the HD_W function (clog2) and the state enum.
REQ-038 Sub-module hamming_popcount (combinational, parameter WIDTH, inputs a and b, output hd[HD_W-1:0]) SHALL be instantiated once.
REQ-039 hamming_popcount SHALL be reusable as a standalone miter deviation cell.

Verification
REQ-040 start, num_samples=4, pairs with distances 0, 3, 64, 1, in_valid held high -> done 2 cycles after the 4th handshake; sum_hd=68, max_hd=64, err_cnt=3.
REQ-041 start, num_samples=0 -> done=1 on the next cycle; sum_hd=0, max_hd=0, err_cnt=0; in_ready never high.
REQ-042 num_samples=3 with in_valid toggling 1,0,0,1,0,1 -> exactly 3 handshakes; results match a software model; in_ready=0 after the 3rd.
REQ-043 rst asserted after 2 of 5 samples -> next cycle all outputs 0 and state IDLE; a new start with num_samples=1 and a=b -> sum_hd=0, err_cnt=0, done=1.
REQ-044 start pulsed during RUN with num_samples=9 -> ignored; the original run of 2 completes with correct totals.
REQ-045 Back-to-back runs: start asserted in DONE -> accumulators clear on that edge; the second run's results are independent of the first.

Source files
------------

// File: rtl/mhd_stream_accumulator_pkg.sv
// Shared definitions for the Hamming-distance stream accumulator and its
// popcount cell.
package mhd_pkg;

    localparam int WIDTH_DEF = 64;
    localparam int CNT_W_DEF = 32;

    // Bits needed to hold a distance in 0..width inclusive.
    function automatic int hd_w(input int width);
        return $clog2(width + 1);
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mhd_stream_accumulator_if.sv
// Valid/ready stream carrying one exact/approximate output pair per beat.
interface mhd_stream_accumulator_if
    import mhd_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;

    modport master (output in_valid, a, b, input in_ready);
    modport slave  (input in_valid, a, b, output in_ready);
endinterface

// File: rtl/mhd_stream_accumulator_popcount.sv
// Combinational Hamming distance between two words; usable on its own as a
// miter deviation cell.
module hamming_popcount
    import mhd_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEF,
    localparam int HD_W  = hd_w(WIDTH)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [HD_W-1:0]  hd
);

    logic [WIDTH-1:0] diff;

    assign diff = a ^ b;

    always_comb begin
        hd = '0;
        for (int i = 0; i < WIDTH; i++) begin
            hd = hd + HD_W'(diff[i]);
        end
    end

endmodule

// File: rtl/mhd_stream_accumulator.sv
// Accumulates sum, maximum and nonzero-count of per-sample Hamming distances
// over a run of num_samples handshaked a/b pairs.
module mhd_stream_accumulator
    import mhd_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEF,
    parameter  int CNT_W = CNT_W_DEF,
    localparam int HD_W  = hd_w(WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_W-1:0]      num_samples,
    mhd_stream_accumulator_if.slave strm,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W+HD_W-1:0] sum_hd,
    output logic [HD_W-1:0]       max_hd,
    output logic [CNT_W-1:0]      err_cnt
);

    state_t           state, state_n;
    logic [CNT_W-1:0] remaining;
    logic [HD_W-1:0]  hd, hd_q;
    logic             hd_v;
    logic             fire;
    logic             start_ok;

    hamming_popcount #(.WIDTH(WIDTH)) u_pop (
        .a  (strm.a),
        .b  (strm.b),
        .hd (hd)
    );

    // Ready depends only on registered state, never on in_valid.
    assign strm.in_ready = (state == RUN) && (remaining != '0);
    assign fire          = strm.in_valid && strm.in_ready;
    assign start_ok      = start && ((state == IDLE) || (state == DONE));
    assign busy          = (state == RUN) || (state == DRAIN);
    assign done          = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: if (start) state_n = (num_samples == '0) ? DONE : RUN;
            RUN:        if (fire && (remaining == CNT_W'(1))) state_n = DRAIN;
            DRAIN:      state_n = DONE;
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            remaining <= '0;
            hd_q      <= '0;
            hd_v      <= 1'b0;
            sum_hd    <= '0;
            max_hd    <= '0;
            err_cnt   <= '0;
        end else begin
            hd_v <= fire;
            if (fire) begin
                hd_q      <= hd;
                remaining <= remaining - CNT_W'(1);
            end
            // Stage 1 is always empty when a start is accepted, so clearing wins.
            if (start_ok) begin
                remaining <= num_samples;
                sum_hd    <= '0;
                max_hd    <= '0;
                err_cnt   <= '0;
            end else if (hd_v) begin
                sum_hd  <= sum_hd + (CNT_W+HD_W)'(hd_q);
                err_cnt <= err_cnt + CNT_W'(hd_q != '0);
                if (hd_q > max_hd) max_hd <= hd_q;
            end
        end
    end

endmodule

// File: tb/tb_mhd_stream_accumulator.sv
// Self-checking bench: per-vector table runs plus hand-built multi-cycle
// sequences, with a scoreboard of expected per-sample distances.
module tb_mhd_stream_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] num_samples;
    logic        busy, done;
    logic [38:0] sum_hd;
    logic [6:0]  max_hd;
    logic [31:0] err_cnt;

    mhd_stream_accumulator_if #(.WIDTH(64)) strm ();

    mhd_stream_accumulator #(.WIDTH(64), .CNT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_samples (num_samples),
        .strm        (strm),
        .busy        (busy),
        .done        (done),
        .sum_hd      (sum_hd),
        .max_hd      (max_hd),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        int          exp_hd;
    } vec_t;

    vec_t        tbl [6];
    logic [63:0] qa [$];
    logic [63:0] qb [$];
    bit          vpat [$];
    int          exp_q [$];
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One complete run from IDLE/DONE; samples come from qa/qb, in_valid from vpat.
    task automatic do_run(input string nm, input logic [31:0] n, input int start_at);
        int     hs, cyc, last_hs, h, em, ee;
        longint es;
        bit     v, rdy_late;
        hs = 0; cyc = 0; last_hs = -10; rdy_late = 0;
        start = 1'b1; num_samples = n;
        step();
        start = 1'b0;
        while (!done && cyc < 200) begin
            v = (vpat.size() > 0) ? vpat.pop_front() : 1'b1;
            start = (cyc == start_at);
            if (cyc == start_at) num_samples = 32'd9;
            if (hs == int'(n) && strm.in_ready) rdy_late = 1;
            strm.in_valid = v && (qa.size() > 0);
            if (qa.size() > 0) begin
                strm.a = qa[0];
                strm.b = qb[0];
            end
            if (strm.in_valid && strm.in_ready) begin
                exp_q.push_back($countones(strm.a ^ strm.b));
                void'(qa.pop_front());
                void'(qb.pop_front());
                hs++;
                last_hs = cyc;
            end
            step();
            cyc++;
        end
        start = 1'b0;
        strm.in_valid = 1'b0;
        vpat.delete();
        chk({nm, " done_reached"}, done, 1);
        chk({nm, " handshakes"}, hs, n);
        if (n == 0) chk({nm, " done_latency"}, cyc, 0);
        else        chk({nm, " done_latency"}, cyc - last_hs, 2);
        chk({nm, " ready_after_last"}, rdy_late, 0);
        chk({nm, " ready_in_done"}, strm.in_ready, 0);
        es = 0; em = 0; ee = 0;
        while (exp_q.size() > 0) begin
            h = exp_q.pop_front();
            es += h;
            if (h > em) em = h;
            if (h != 0) ee++;
        end
        chk({nm, " sum_hd"}, sum_hd, es);
        chk({nm, " max_hd"}, max_hd, em);
        chk({nm, " err_cnt"}, err_cnt, ee);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{64'h0, 64'h0, 0};
        tbl[1] = '{64'hA5, 64'hA2, 3};
        tbl[2] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64};
        tbl[3] = '{64'hDEAD_BEEF_0000_0000, 64'hDEAD_BEEF_0000_0010, 1};
        tbl[4] = '{64'hFF00, 64'h0F00, 4};
        tbl[5] = '{64'h8000_0000_0000_0001, 64'h0, 2};

        // Reset held while start and in_valid are also asserted.
        rst = 1'b1; start = 1'b1; num_samples = 32'd3;
        strm.in_valid = 1'b1; strm.a = '1; strm.b = '0;
        step();
        step();
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst in_ready", strm.in_ready, 0);
        chk("rst sum_hd", sum_hd, 0);
        chk("rst max_hd", max_hd, 0);
        chk("rst err_cnt", err_cnt, 0);

        // in_valid while idle is ignored.
        rst = 1'b0; start = 1'b0;
        step(); step(); step();
        chk("idle_valid busy", busy, 0);
        chk("idle_valid sum_hd", sum_hd, 0);
        chk("idle_valid err_cnt", err_cnt, 0);
        strm.in_valid = 1'b0;

        // One single-sample run per table vector, back to back from DONE.
        foreach (tbl[i]) begin
            qa.push_back(tbl[i].a);
            qb.push_back(tbl[i].b);
            do_run($sformatf("vec%0d", i), 32'd1, -1);
            chk($sformatf("vec%0d table_sum", i), sum_hd, tbl[i].exp_hd);
            chk($sformatf("vec%0d table_max", i), max_hd, tbl[i].exp_hd);
        end

        for (int i = 0; i < 4; i++) begin
            qa.push_back(tbl[i].a);
            qb.push_back(tbl[i].b);
        end
        do_run("run4", 32'd4, -1);
        chk("run4 fixed sum", sum_hd, 68);
        chk("run4 fixed max", max_hd, 64);
        chk("run4 fixed err", err_cnt, 3);

        do_run("zero", 32'd0, -1);
        chk("zero fixed sum", sum_hd, 0);

        for (int i = 0; i < 3; i++) begin
            qa.push_back({$urandom(), $urandom()});
            qb.push_back({$urandom(), $urandom()});
        end
        vpat = '{1, 0, 0, 1, 0, 1};
        do_run("stall", 32'd3, -1);

        // Abort a 5-sample run after two handshakes.
        start = 1'b1; num_samples = 32'd5;
        step();
        start = 1'b0;
        strm.in_valid = 1'b1; strm.a = '1; strm.b = '0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        strm.in_valid = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort in_ready", strm.in_ready, 0);
        chk("abort sum_hd", sum_hd, 0);
        chk("abort max_hd", max_hd, 0);
        chk("abort err_cnt", err_cnt, 0);
        step();
        chk("abort idle_stays", busy, 0);
        qa.push_back(64'h5555_AAAA_1234_5678);
        qb.push_back(64'h5555_AAAA_1234_5678);
        do_run("post_rst", 32'd1, -1);
        chk("post_rst fixed err", err_cnt, 0);

        // start pulsed mid-run must be ignored.
        qa.push_back(64'hF);
        qb.push_back(64'h0);
        qa.push_back(64'hFF);
        qb.push_back(64'h0);
        vpat = '{1, 0, 0, 1};
        do_run("ign_start", 32'd2, 1);
        chk("ign_start fixed sum", sum_hd, 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
